// File: rtl/word_time_sched.sv
// Word-time scheduler: tracks the drum word number from T29/T0 and opens a
// whole-word transfer gate, either deferred (at word T) or immediate (up to T).
module word_time_sched #(
  parameter int WORDS = 108,
  parameter int CW    = 7
) (
  input  logic          CLOCK,
  input  logic          rst,
  input  logic          T0,
  input  logic          T29,
  input  logic          start,
  input  logic [CW-1:0] t_num,
  input  logic          imm,
  input  logic          dbl,
  input  logic          abort,
  output logic [CW-1:0] word_cnt,
  output logic          sync,
  output logic          busy,
  output logic          xfer_gate,
  output logic          done,
  output logic          sync_err,
  output logic          cmd_err
);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_t;
  typedef struct packed {
    logic [CW-1:0] tgt;
    logic [1:0]    len;
    logic          imm;
  } cmd_t;

  state_t        state_q, state_d;
  cmd_t          cmd_q, cmd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_q, sync_d, serr_q, serr_set;
  logic          gate_q, gate_d, done_q, done_d, cerr_q, cerr_d;
  logic          t_ok, kill;

  // cnt_d is the number of the word that begins on the next clock
  always_comb begin
    cnt_d    = cnt_q;
    sync_d   = sync_q;
    serr_set = 1'b0;
    if (T29) begin
      if (T0) begin
        cnt_d    = '0;
        sync_d   = 1'b1;
        serr_set = sync_q && (cnt_q != LAST);
      end else begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      end
    end
  end

  assign t_ok = ({1'b0, t_num} < (CW+1)'(WORDS));
  assign kill = abort | serr_set;

  always_ff @(posedge CLOCK) begin
    if (rst) begin
      cnt_q   <= '0;
      sync_q  <= 1'b0;
      serr_q  <= 1'b0;
      state_q <= S_IDLE;
      cmd_q   <= '0;
      gate_q  <= 1'b0;
      done_q  <= 1'b0;
      cerr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sync_q  <= sync_d;
      serr_q  <= serr_q | serr_set;
      state_q <= state_d;
      cmd_q   <= cmd_d;
      gate_q  <= gate_d;
      done_q  <= done_d;
      cerr_q  <= cerr_d;
    end
  end

  // WAIT/XFER only move on T29 edges so the gate always spans whole words
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    unique case (state_q)
      S_IDLE: begin
        if (start && !abort && sync_q && t_ok) begin
          state_d   = S_WAIT;
          cmd_d.tgt = (!imm && dbl) ? (t_num & ~CW'(1)) : t_num;
          cmd_d.len = dbl ? 2'd2 : 2'd1;
          cmd_d.imm = imm;
        end
      end
      S_WAIT: begin
        if (T29) begin
          if (cnt_d == cmd_q.tgt) state_d = cmd_q.imm ? S_IDLE : S_XFER;
          else if (cmd_q.imm)     state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (T29) begin
          if (cmd_q.imm) begin
            if (cnt_d == cmd_q.tgt) state_d = S_IDLE;
          end else begin
            cmd_d.len = cmd_q.len - 2'd1;
            if (cmd_q.len == 2'd1) state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (kill && state_q != S_IDLE) state_d = S_IDLE;
  end

  always_comb begin
    gate_d = (state_d == S_XFER);
    done_d = (state_q != S_IDLE) && (state_d == S_IDLE) && !kill;
    cerr_d = (state_q == S_IDLE) && start && !abort && !(sync_q && t_ok);
  end

  assign word_cnt  = cnt_q;
  assign sync      = sync_q;
  assign busy      = (state_q != S_IDLE);
  assign xfer_gate = gate_q;
  assign done      = done_q;
  assign sync_err  = serr_q;
  assign cmd_err   = cerr_q;
endmodule

// File: tb/tb_word_time_sched.sv
// Scoreboard bench for word_time_sched: a timing-gate generator, a monitor
// that measures gate windows and done/cmd_err events, and directed commands.
module tb_word_time_sched;
  localparam int WORDS = 108;
  localparam int CW    = 7;
  localparam int WCLK  = 29;
  localparam int REV   = WORDS * WCLK;
  localparam int KD    = 1;
  localparam int KC    = 2;

  logic          CLOCK = 1'b0;
  logic          rst = 1'b1, T0 = 1'b0, T29 = 1'b0, start = 1'b0;
  logic          imm = 1'b0, dbl = 1'b0, abort = 1'b0;
  logic [CW-1:0] t_num = '0;
  logic [CW-1:0] word_cnt;
  logic          sync, busy, xfer_gate, done, sync_err, cmd_err;

  typedef struct {
    int kind;
    int gclk;
    int gw;
    int dw;
  } exp_t;
  exp_t sb[$];
  exp_t me;

  int   n_cmp = 0, n_err = 0;
  int   bt = 5, wd = 100, cur_bt = 0, cur_wd = 0;
  logic inj = 1'b0;
  int   tx_id = 0, seen = 0, gcnt = 0, gw = 0, gb = 0;

  word_time_sched #(.WORDS(WORDS), .CW(CW)) dut (
    .CLOCK(CLOCK), .rst(rst), .T0(T0), .T29(T29), .start(start),
    .t_num(t_num), .imm(imm), .dbl(dbl), .abort(abort),
    .word_cnt(word_cnt), .sync(sync), .busy(busy), .xfer_gate(xfer_gate),
    .done(done), .sync_err(sync_err), .cmd_err(cmd_err)
  );

  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Timing gates: cur_* describe the bit time ending at the next posedge
  initial forever begin
    @(negedge CLOCK);
    T29    = (bt == WCLK-1);
    T0     = T29 && (wd == WORDS-1 || (inj && wd == 50));
    cur_bt = bt;
    cur_wd = wd;
    if (bt == WCLK-1) begin
      bt = 0;
      wd = (T0 || wd == WORDS-1) ? 0 : wd + 1;
    end else begin
      bt = bt + 1;
    end
  end

  // Monitor: bt/wd here name the bit time whose outputs are being sampled
  initial forever begin
    @(posedge CLOCK);
    #2;
    if (seen != tx_id) begin
      gcnt = 0;
      seen = tx_id;
    end
    if (xfer_gate === 1'b1) begin
      if (gcnt == 0) begin
        gw = wd;
        gb = bt;
      end
      gcnt++;
    end
    if (done === 1'b1 || cmd_err === 1'b1) begin
      if (sb.size() == 0) chk("unexp_evt", {30'd0, done, cmd_err}, 0);
      else begin
        me = sb.pop_front();
        chk("evt_kind", (done === 1'b1) ? KD : KC, me.kind);
        if (me.kind == KD) begin
          chk("gate_clks", gcnt, me.gclk);
          if (me.gclk > 0) begin
            chk("gate_word", gw, me.gw);
            chk("gate_bit", gb, 0);
          end
          chk("done_word", wd, me.dw);
          chk("done_bit", bt, 0);
          chk("done_busy", busy, 0);
        end else begin
          chk("cerr_busy", busy, 0);
        end
        gcnt = 0;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(negedge CLOCK);
    #1;
  endtask

  task automatic wait_at(input int w, input int b);
    bit hit = 1'b0;
    for (int n = 0; n < 3*REV && !hit; n++) begin
      step();
      hit = (cur_wd == w && cur_bt == b);
    end
    chk("wait_at", hit, 1);
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int n = 0; n < 3*REV && !ok; n++) begin
      step();
      ok = (sb.size() == 0);
    end
    chk("sb_drain", sb.size(), 0);
  endtask

  function automatic void push_exp(input int kind, input int s, input int tn,
                                   input bit im, input bit db);
    exp_t e;
    int   nw, tg;
    e.kind = kind; e.gclk = 0; e.gw = 0; e.dw = 0;
    if (kind == KD) begin
      if (im) begin
        nw     = (tn - (s + 1) + 2*WORDS) % WORDS;
        e.gclk = nw * WCLK;
        e.gw   = (s + 1) % WORDS;
        e.dw   = tn;
      end else begin
        tg     = db ? (tn & ~1) : tn;
        e.gclk = db ? 2*WCLK : WCLK;
        e.gw   = tg;
        e.dw   = (tg + (db ? 2 : 1)) % WORDS;
      end
    end
    sb.push_back(e);
  endfunction

  // kind 0: no completion event expected (command is cancelled or dropped)
  task automatic issue(input int tn, input bit im, input bit db, input int kind);
    start = 1'b1;
    t_num = CW'(tn);
    imm   = im;
    dbl   = db;
    tx_id++;
    if (kind != 0) push_exp(kind, cur_wd, tn, im, db);
    step();
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) step();
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_sync", sync, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gate", xfer_gate, 0);
    chk("rst_done", done, 0);
    chk("rst_sync_err", sync_err, 0);
    chk("rst_cmd_err", cmd_err, 0);
    rst = 1'b0;
    step();

    // start before the first index is rejected
    issue(5, 1'b0, 1'b0, KC);
    chk("presync_cerr", cmd_err, 1);
    chk("presync_busy", busy, 0);
    step();
    chk("cerr_one_clk", cmd_err, 0);

    // free-run two revolutions after the index
    wait_at(0, 5);
    chk("sync_after_t0", sync, 1);
    for (int k = 0; k < 2*WORDS; k++) begin
      repeat (WCLK) step();
      chk("word_cnt", word_cnt, cur_wd);
    end
    chk("no_sync_err", sync_err, 0);

    // deferred single, double, double at the last word pair
    wait_at(10, 10); issue(5, 1'b0, 1'b0, KD);   drain();
    wait_at(20, 10); issue(7, 1'b0, 1'b1, KD);   drain();
    wait_at(30, 10); issue(107, 1'b0, 1'b1, KD); drain();

    // immediate across the wrap, then zero-length immediate
    wait_at(105, 10); issue(2, 1'b1, 1'b0, KD);  drain();
    wait_at(20, 10);  issue(21, 1'b1, 1'b0, KD); drain();

    // out-of-range word number
    wait_at(30, 3);
    issue(108, 1'b0, 1'b0, KC);
    chk("range_cerr", cmd_err, 1);
    chk("range_busy", busy, 0);
    step();
    chk("range_cerr_1clk", cmd_err, 0);

    // abort together with start drops the start
    wait_at(35, 3);
    abort = 1'b1;
    issue(40, 1'b0, 1'b0, 0);
    abort = 1'b0;
    chk("abst_busy", busy, 0);
    chk("abst_cerr", cmd_err, 0);

    // abort in the middle of a double transfer
    wait_at(40, 3);
    issue(45, 1'b0, 1'b1, 0);
    wait_at(45, 10);
    chk("xfer_gate_on", xfer_gate, 1);
    chk("xfer_busy", busy, 1);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_gate", xfer_gate, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    repeat (3*WCLK) step();

    // reset while waiting
    wait_at(50, 3);
    issue(60, 1'b0, 1'b0, 0);
    wait_at(55, 10);
    chk("wait_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rstw_gate", xfer_gate, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_sync", sync, 0);
    chk("rstw_cnt", word_cnt, 0);
    chk("rstw_done", done, 0);
    wait_at(60, 10);
    chk("rstw_no_gate", xfer_gate, 0);
    wait_at(0, 5);
    chk("resync", sync, 1);
    chk("resync_cnt", word_cnt, 0);

    // misplaced index while a deferred transfer waits
    wait_at(45, 3);
    issue(80, 1'b0, 1'b0, 0);
    wait_at(50, 5);
    chk("inj_busy", busy, 1);
    inj = 1'b1;
    wait_at(0, 0);
    inj = 1'b0;
    chk("inj_sync_err", sync_err, 1);
    chk("inj_cnt", word_cnt, 0);
    chk("inj_busy_off", busy, 0);
    chk("inj_gate", xfer_gate, 0);
    chk("inj_done", done, 0);
    wait_at(82, 0);
    chk("sync_err_sticky", sync_err, 1);

    chk("sb_empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
